cmult_stream: RTL and testbench
===============================

Name: cmult_stream

Overview:
- Next-generation complex multiplier for the DSP datapath: p = a*b, or p = a*conj(b) selected per sample.
- Independent input widths, a 3-multiplier pre-adder structure and a full-precision internal result.
- Output is scaled by a compile-time right shift with round-half-up and narrowed to OUT_WIDTH.
- Valid/ready handshake with backpressure on both sides, replacing the free-running valid shift register of the previous generation. It sits between FFT/mixer stages that can stall.

Parameters:
A_WIDTH, 16, signed width of ar/ai
B_WIDTH, 16, signed width of br/bi
OUT_WIDTH, 16, signed width of pr/pi
SHIFT, 15, arithmetic right shift applied to the full-precision result (0..A_WIDTH+B_WIDTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept input this cycle
conj_b  in  1  1: use conj(b) for this sample
ar, ai  in  A_WIDTH  signed operand a, real/imag
br, bi  in  B_WIDTH  signed operand b, real/imag
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts output
pr, pi  out  OUT_WIDTH  signed scaled product, real/imag
ovf  out  1  pr or pi of the current output saturated (see Optional Feature)

Behaviour:
- Reset: async assert on rst_n low. All valid flags clear; m_valid=0, pr=0, pi=0, ovf=0. Data registers need no reset beyond the outputs. A reset mid-operation discards all in-flight samples.
- Transfers:
  - Input transfer occurs when s_valid & s_ready.
  - Output transfer occurs when m_valid & m_ready.
- Pipeline and stalls:
  - 6-stage pipeline with a single global enable: en = ~m_valid | m_ready.
  - s_ready = en (combinational from m_valid/m_ready only; must not depend on s_valid).
  - When en=0, every stage holds its data and valid.
  - Bubbles propagate as valid=0 stages; no bubble collapsing is required.
- Latency: exactly 6 clk from input transfer to m_valid when unstalled. Throughput is 1 sample/clk. Order is always preserved.
- Stage 1: register inputs and conj_b.
  - bi is sign-extended to B_WIDTH+1 and negated if conj_b, so -2^(B_WIDTH-1) conjugates exactly.
- Stages 2-4 (3-multiplier form):
  - common = (ar - ai)*bi'
  - pr_full = (br - bi')*ar + common
  - pi_full = (br + bi')*ai + common
  - FULL_W = A_WIDTH + B_WIDTH + 3.
  - No intermediate truncation; all sums are signed and sign-extended.
- Stage 5: round. r = (full + 2^(SHIFT-1)) >>> SHIFT; when SHIFT=0 there is no add. The add must not overflow (FULL_W has headroom).
- Stage 6: narrow r to OUT_WIDTH (saturate or wrap, see below) and register into pr/pi/ovf.
- m_valid holds with stable pr/pi/ovf until the output transfer completes.

Optional Feature:
- Macro CMULT_SATURATE_EN.
- Defined: if r is outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], clamp to the nearest bound. ovf=1 for that output when either pr or pi clamped.
- Undefined: keep the low OUT_WIDTH bits (two's-complement wrap); ovf is tied 0.

Decomposition:
- Package cmult_pkg:
  - localparam CMULT_LATENCY=6
  - function for full-width computation (A_WIDTH+B_WIDTH+3)
  - function round_shift(value, shift)
- One sub-module cmult_round_sat: stages 5-6 for a single real lane, instantiated twice (pr, pi), with its own en input and optional saturation.

Test Plan:
- Basic: a=(16384,0), b=(16384,16384), conj_b=0, m_ready=1 -> 6 clk later pr=8192, pi=8192, ovf=0.
- Conjugate: a=(0,16384), b=(0,16384).
  - conj_b=0 -> pr=-8192, pi=0.
  - conj_b=1 -> pr=8192, pi=0.
- Rounding: a=(1,0).
  - b=(16384,0) -> pr=1.
  - b=(16383,0) -> pr=0.
  - b=(-16384,0) -> pr=0 (half rounds toward +inf).
- Extremes: a=(-32768,0), b=(-32768,0).
  - With CMULT_SATURATE_EN -> pr=32767, pi=0, ovf=1.
  - Without -> pr=-32768, ovf=0.
- Backpressure: stream 20 incrementing samples with s_valid=1 continuously, m_ready=0 for cycles 8-17.
  - s_ready=0 exactly while m_valid & ~m_ready.
  - All 20 results arrive in order, none duplicated or lost.
  - pr/pi stable while stalled.
- Reset mid-stream: assert rst_n=0 with 4 samples in flight -> m_valid=0, pr=pi=0 immediately (async). After release, a new sample appears 6 clk after acceptance, with no stale outputs.

Source files
------------

// File: rtl/cmult_pkg.sv
// Shared constants and helpers for the streaming complex multiplier.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package cmult_pkg;

    // Register stages from input transfer to m_valid.
    localparam int CMULT_LATENCY = 6;

    // Full-precision result width: one bit for each pre-add, one for the
    // conjugate negation and one for the final post-add.
    function automatic int full_width(input int a_w, input int b_w);
        return a_w + b_w + 3;
    endfunction

    // Arithmetic right shift with round-half-up (ties go toward +inf).
    // Callers sign-extend into 64 bits; results never need more than the
    // caller's full width because the operand carries headroom.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                       input int shift);
        logic signed [63:0] half;
        if (shift <= 0) begin
            return value;
        end
        half = 64'sd1 <<< (shift - 1);
        return (value + half) >>> shift;
    endfunction

endpackage

// File: rtl/cmult_stream_if.sv
// Handshake and data bundle for the streaming complex multiplier.
// Latency: n/a (wiring only).
// Backpressure: s_ready/m_ready carry stalls against the data direction.
interface cmult_stream_if #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 16
);
    logic                        s_valid;
    logic                        s_ready;
    logic                        conj_b;
    logic signed [A_WIDTH-1:0]   ar;
    logic signed [A_WIDTH-1:0]   ai;
    logic signed [B_WIDTH-1:0]   br;
    logic signed [B_WIDTH-1:0]   bi;
    logic                        m_valid;
    logic                        m_ready;
    logic signed [OUT_WIDTH-1:0] pr;
    logic signed [OUT_WIDTH-1:0] pi;
    logic                        ovf;

    // Side that produces operands and consumes products.
    modport master (
        output s_valid, conj_b, ar, ai, br, bi, m_ready,
        input  s_ready, m_valid, pr, pi, ovf
    );

    // The multiplier itself.
    modport slave (
        input  s_valid, conj_b, ar, ai, br, bi, m_ready,
        output s_ready, m_valid, pr, pi, ovf
    );
endinterface

// File: rtl/cmult_round_sat.sv
// One real lane of the output: round-half-up shift, then narrow (clamp or wrap).
// Latency: 2 clk (round register, output register), both gated by en.
// Backpressure: holds both stages while en=0; output loads only for valid samples. Clamping under CMULT_SATURATE_EN.
module cmult_round_sat
    import cmult_pkg::*;
#(
    parameter int FULL_W    = 35,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        in_valid,
    input  logic signed [FULL_W-1:0]    full,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        ovf
);

    logic signed [63:0]          full_ext;
    logic signed [63:0]          rnd;
    logic signed [FULL_W-1:0]    r5;
    logic signed [OUT_WIDTH-1:0] nar;
    logic                        flag;
    logic                        unused_bits;

    assign full_ext = {{(64 - FULL_W){full[FULL_W-1]}}, full};
    assign rnd      = round_shift(full_ext, SHIFT);

    // Stage 5: rounded value; the rounding add cannot leave FULL_W bits.
    always_ff @(posedge clk) begin
        if (en) begin
            r5 <= rnd[FULL_W-1:0];
        end
    end

`ifdef CMULT_SATURATE_EN
    localparam logic signed [FULL_W-1:0] MAX_V =
        {{(FULL_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [FULL_W-1:0] MIN_V =
        {{(FULL_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    assign unused_bits = ^rnd[63:FULL_W];

    // Clamp to the nearest representable bound and flag it.
    always_comb begin
        nar  = r5[OUT_WIDTH-1:0];
        flag = 1'b0;
        if (r5 > MAX_V) begin
            nar  = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            flag = 1'b1;
        end else if (r5 < MIN_V) begin
            nar  = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            flag = 1'b1;
        end
    end
`else
    assign unused_bits = ^{rnd[63:FULL_W], r5[FULL_W-1:OUT_WIDTH]};

    // Two's-complement wrap: keep the low bits, never flag.
    always_comb begin
        nar  = r5[OUT_WIDTH-1:0];
        flag = 1'b0;
    end
`endif

    // Stage 6: output register, updated only when a real sample arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            ovf  <= 1'b0;
        end else if (en && in_valid) begin
            dout <= nar;
            ovf  <= flag;
        end
    end

endmodule

// File: rtl/cmult_stream.sv
// Streaming complex multiply p = a*b or a*conj(b), 3-multiplier form, scaled and narrowed.
// Latency: 6 clk from input transfer to m_valid, 1 sample/clk. Optional clamp: CMULT_SATURATE_EN.
// Backpressure: single global enable en = ~m_valid | m_ready; s_ready = en; all stages hold when stalled.
module cmult_stream
    import cmult_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15
) (
    input logic           clk,
    input logic           rst_n,
    cmult_stream_if.slave bus
);

    localparam int FULL_W = full_width(A_WIDTH, B_WIDTH);
    localparam int AW1    = A_WIDTH + 1;
    localparam int BW1    = B_WIDTH + 1;
    localparam int BW2    = B_WIDTH + 2;

    logic                        en;
    logic [CMULT_LATENCY-1:0]    vld;

    // Stage 1: registered operands, b imaginary already conjugated.
    logic signed [A_WIDTH-1:0]   ar1, ai1;
    logic signed [B_WIDTH-1:0]   br1;
    logic signed [BW1-1:0]       bi1;
    // Stage 2: pre-adds.
    logic signed [AW1-1:0]       d2;
    logic signed [BW2-1:0]       sr2, si2;
    logic signed [A_WIDTH-1:0]   ar2, ai2;
    logic signed [BW1-1:0]       bi2;
    // Stage 3: the three products.
    logic signed [FULL_W-1:0]    com3, mr3, mi3;
    // Stage 4: full-precision result.
    logic signed [FULL_W-1:0]    prf4, pif4;

    logic                        ovf_r, ovf_i;

    assign en          = ~bus.m_valid | bus.m_ready;
    assign bus.s_ready = en;
    assign bus.m_valid = vld[CMULT_LATENCY-1];
    assign bus.ovf     = ovf_r | ovf_i;

    // Valid shift register; with en=1 s_ready=1, so shifting s_valid in is the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[CMULT_LATENCY-2:0], bus.s_valid};
        end
    end

    // Stages 1-4 datapath; no reset needed since valids qualify the data.
    always_ff @(posedge clk) begin
        if (en) begin
            ar1  <= bus.ar;
            ai1  <= bus.ai;
            br1  <= bus.br;
            // One extra bit lets the most negative bi conjugate exactly.
            bi1  <= bus.conj_b ? -BW1'(bus.bi) : BW1'(bus.bi);

            d2   <= AW1'(ar1) - AW1'(ai1);
            sr2  <= BW2'(br1) - BW2'(bi1);
            si2  <= BW2'(br1) + BW2'(bi1);
            ar2  <= ar1;
            ai2  <= ai1;
            bi2  <= bi1;

            com3 <= FULL_W'(d2)  * FULL_W'(bi2);
            mr3  <= FULL_W'(sr2) * FULL_W'(ar2);
            mi3  <= FULL_W'(si2) * FULL_W'(ai2);

            prf4 <= mr3 + com3;
            pif4 <= mi3 + com3;
        end
    end

    cmult_round_sat #(
        .FULL_W   (FULL_W),
        .OUT_WIDTH(OUT_WIDTH),
        .SHIFT    (SHIFT)
    ) u_lane_re (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_valid(vld[CMULT_LATENCY-2]),
        .full    (prf4),
        .dout    (bus.pr),
        .ovf     (ovf_r)
    );

    cmult_round_sat #(
        .FULL_W   (FULL_W),
        .OUT_WIDTH(OUT_WIDTH),
        .SHIFT    (SHIFT)
    ) u_lane_im (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_valid(vld[CMULT_LATENCY-2]),
        .full    (pif4),
        .dout    (bus.pi),
        .ovf     (ovf_i)
    );

endmodule

// File: tb/tb_cmult_stream.sv
// Directed bench for cmult_stream with a scoreboard queue of expected products.
// Latency: checks the 6 clk input-to-output delay on an empty pipeline.
// Backpressure: checks s_ready against m_valid/m_ready and output stability while stalled.
module tb_cmult_stream;

    localparam int AW = 16;
    localparam int BW = 16;
    localparam int OW = 16;
    localparam int SH = 15;

    typedef struct packed {
        logic signed [OW-1:0] pr;
        logic signed [OW-1:0] pi;
        logic                 ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cmult_stream_if #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW)) bus ();

    cmult_stream #(
        .A_WIDTH  (AW),
        .B_WIDTH  (BW),
        .OUT_WIDTH(OW),
        .SHIFT    (SH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                n_out  = 0;
    bit                mon_en = 1'b0;
    bit                stall_prev = 1'b0;
    logic [2*OW:0]     hold_prev;

    function automatic exp_t mk(input int pr, input int pi, input bit o);
        exp_t e;
        e.pr  = OW'(pr);
        e.pi  = OW'(pi);
        e.ovf = o;
        return e;
    endfunction

    function automatic void narrow(input longint v, output logic signed [OW-1:0] o,
                                   output bit clamped);
`ifdef CMULT_SATURATE_EN
        clamped = 1'b1;
        if (v > 32767)       o = 16'sh7fff;
        else if (v < -32768) o = 16'sh8000;
        else begin
            o       = OW'(v);
            clamped = 1'b0;
        end
`else
        o       = OW'(v);
        clamped = 1'b0;
`endif
    endfunction

    // Direct four-multiply reference with round-half-up.
    function automatic exp_t model(input int ar, input int ai, input int br, input int bi,
                                   input bit cj);
        longint bip, re, im, half;
        bit     c1, c2;
        exp_t   e;
        bip  = cj ? -longint'(bi) : longint'(bi);
        re   = longint'(ar) * longint'(br) - longint'(ai) * bip;
        im   = longint'(ai) * longint'(br) + longint'(ar) * bip;
        half = longint'(1) <<< (SH - 1);
        narrow((re + half) >>> SH, e.pr, c1);
        narrow((im + half) >>> SH, e.pi, c2);
        e.ovf = c1 | c2;
        return e;
    endfunction

    // Output monitor: handshake rule, stall stability, scoreboard pop.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            checks++;
            assert (bus.s_ready === !(bus.m_valid && !bus.m_ready)) else begin
                errors++;
                $error("FAIL s_ready: observed %0b expected %0b", bus.s_ready,
                       !(bus.m_valid && !bus.m_ready));
            end
            if (bus.m_valid && !bus.m_ready && stall_prev) begin
                checks++;
                assert ({bus.pr, bus.pi, bus.ovf} === hold_prev) else begin
                    errors++;
                    $error("FAIL stall_hold: observed %h expected %h",
                           {bus.pr, bus.pi, bus.ovf}, hold_prev);
                end
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            hold_prev  = {bus.pr, bus.pi, bus.ovf};
            if (bus.m_valid && bus.m_ready) begin
                n_out++;
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_out: observed pr=%0d pi=%0d expected no output",
                           bus.pr, bus.pi);
                end
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    assert (bus.pr === e.pr) else begin
                        errors++;
                        $error("FAIL pr: observed %0d expected %0d", bus.pr, e.pr);
                    end
                    checks++;
                    assert (bus.pi === e.pi) else begin
                        errors++;
                        $error("FAIL pi: observed %0d expected %0d", bus.pi, e.pi);
                    end
                    checks++;
                    assert (bus.ovf === e.ovf) else begin
                        errors++;
                        $error("FAIL ovf: observed %0b expected %0b", bus.ovf, e.ovf);
                    end
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one sample until accepted; the expectation is queued at acceptance.
    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input bit cj, input exp_t e);
        bit acc;
        int tries;
        tries       = 0;
        bus.ar      = AW'(ar);
        bus.ai      = AW'(ai);
        bus.br      = BW'(br);
        bus.bi      = BW'(bi);
        bus.conj_b  = cj;
        bus.s_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 200);
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL accept_timeout: observed s_ready %0b expected 1", acc);
        end
        if (acc) sb.push_back(e);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_m(input int ar, input int ai, input int br, input int bi, input bit cj);
        send(ar, ai, br, bi, cj, model(ar, ai, br, bi, cj));
    endtask

    // Count negedges from just after acceptance until m_valid rises.
    task automatic check_latency(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_valid && n < 20);
        checks++;
        assert (n == 6) else begin
            errors++;
            $error("FAIL latency_%s: observed %0d expected 6", tag, n);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain_%s: observed %0d pending expected 0", tag, sb.size());
        end
    endtask

    initial begin
        int base;
        int seen;
        bus.s_valid = 1'b0;
        bus.conj_b  = 1'b0;
        bus.ar      = '0;
        bus.ai      = '0;
        bus.br      = '0;
        bus.bi      = '0;
        bus.m_ready = 1'b0;

        // Reset state.
        #1 rst_n = 1'b0;
        #12;
        checks++; assert (bus.m_valid === 1'b0) else begin errors++; $error("FAIL rst_m_valid: observed %0b expected 0", bus.m_valid); end
        checks++; assert (bus.pr === 16'sd0) else begin errors++; $error("FAIL rst_pr: observed %0d expected 0", bus.pr); end
        checks++; assert (bus.pi === 16'sd0) else begin errors++; $error("FAIL rst_pi: observed %0d expected 0", bus.pi); end
        checks++; assert (bus.ovf === 1'b0) else begin errors++; $error("FAIL rst_ovf: observed %0b expected 0", bus.ovf); end
        checks++; assert (bus.s_ready === 1'b1) else begin errors++; $error("FAIL rst_s_ready: observed %0b expected 1", bus.s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        mon_en      = 1'b1;

        // Basic product and latency on an empty pipeline.
        send(16384, 0, 16384, 16384, 1'b0, mk(8192, 8192, 0));
        check_latency("basic");
        idle(4);

        // Conjugate select.
        send(0, 16384, 0, 16384, 1'b0, mk(-8192, 0, 0));
        send(0, 16384, 0, 16384, 1'b1, mk(8192, 0, 0));
        // Rounding: half up, below half, negative half.
        send(1, 0, 16384, 0, 1'b0, mk(1, 0, 0));
        send(1, 0, 16383, 0, 1'b0, mk(0, 0, 0));
        send(1, 0, -16384, 0, 1'b0, mk(0, 0, 0));
        // Most negative operands.
`ifdef CMULT_SATURATE_EN
        send(-32768, 0, -32768, 0, 1'b0, mk(32767, 0, 1));
`else
        send(-32768, 0, -32768, 0, 1'b0, mk(-32768, 0, 0));
`endif
        // Conjugating the most negative bi.
        send_m(-32768, 0, 0, -32768, 1'b1);
        drain("directed");

        // Backpressure: 20 back-to-back samples, m_ready low for cycles 8-17.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send_m(i * 1000, -i * 500, 2000 + i * 37, i * 300 - 3000, i[0]);
                end
            end
            begin
                idle(8);
                bus.m_ready = 1'b0;
                idle(10);
                bus.m_ready = 1'b1;
            end
        join
        drain("stream");
        checks++;
        assert (n_out - base == 20) else begin
            errors++;
            $error("FAIL stream_count: observed %0d expected 20", n_out - base);
        end

        // Reset with four samples in flight.
        for (int i = 0; i < 4; i++) begin
            send_m(3000 + i, 1000, -2000, 500 + i, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; assert (bus.m_valid === 1'b0) else begin errors++; $error("FAIL midrst_m_valid: observed %0b expected 0", bus.m_valid); end
        checks++; assert (bus.pr === 16'sd0) else begin errors++; $error("FAIL midrst_pr: observed %0d expected 0", bus.pr); end
        checks++; assert (bus.pi === 16'sd0) else begin errors++; $error("FAIL midrst_pi: observed %0d expected 0", bus.pi); end
        sb.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.m_valid) seen++;
        end
        @(posedge clk);
        #1;
        checks++;
        assert (seen == 0) else begin
            errors++;
            $error("FAIL stale_out: observed %0d valid cycles expected 0", seen);
        end
        send(16384, 0, 16384, 16384, 1'b1, mk(8192, -8192, 0));
        check_latency("after_reset");
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
